// File: rtl/lcd_pkg.sv
// lcd_pkg: state encoding, 50 MHz default timing and command bytes shared by
// the character-LCD write engine.
package lcd_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE     = 4'd0;
    localparam state_t S_SETUP_HI = 4'd1;
    localparam state_t S_EN_HI    = 4'd2;
    localparam state_t S_HOLD_HI  = 4'd3;
    localparam state_t S_GAP      = 4'd4;
    localparam state_t S_SETUP_LO = 4'd5;
    localparam state_t S_EN_LO    = 4'd6;
    localparam state_t S_HOLD_LO  = 4'd7;
    localparam state_t S_WAIT     = 4'd8;

    localparam int DEF_SETUP_CYC     = 2;
    localparam int DEF_EN_CYC        = 12;
    localparam int DEF_HOLD_CYC      = 1;
    localparam int DEF_GAP_CYC       = 47;
    localparam int DEF_WAIT_CYC      = 2000;
    localparam int DEF_LONG_WAIT_CYC = 82000;
    localparam int DEF_CNT_W         = 17;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Return home also decodes as 8'h03 because bit 0 is don't-care on the LCD.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] b);
        return !rs && (b == CMD_CLEAR || b[7:1] == CMD_HOME[7:1]);
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// lcd_phase_timer: phase counter with synchronous clear and terminal-count flag
// (tc_o is high while the count equals last_i).
module lcd_phase_timer #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] last_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tc_o = cnt_q == last_i;

endmodule

// File: rtl/lcd_write_engine.sv
// lcd_write_engine: one byte per handshake onto a 4/8-bit character-LCD bus with
// programmable phase timing. Define LCD_LONG_WAIT_EN for the long clear/home wait.
module lcd_write_engine
    import lcd_pkg::*;
#(
    parameter int NIBBLE_MODE   = 1,
    parameter int SETUP_CYC     = DEF_SETUP_CYC,
    parameter int EN_CYC        = DEF_EN_CYC,
    parameter int HOLD_CYC      = DEF_HOLD_CYC,
    parameter int GAP_CYC       = DEF_GAP_CYC,
    parameter int WAIT_CYC      = DEF_WAIT_CYC,
    parameter int LONG_WAIT_CYC = DEF_LONG_WAIT_CYC,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rs_in,
    input  logic [7:0] data_in,
    output logic       ready,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_d
);

    localparam bit NIB = NIBBLE_MODE != 0;

    state_t           state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d, e_q, e_d;
    logic             accept, tc, clr, hi, lo;
    logic [CNT_W-1:0] last, wait_last;

    assign accept = start && state_q == S_IDLE;

`ifdef LCD_LONG_WAIT_EN
    assign wait_last = is_slow_cmd(rs_q, data_q) ? CNT_W'(LONG_WAIT_CYC - 1) : CNT_W'(WAIT_CYC - 1);
`else
    logic unused_long_wait;
    assign unused_long_wait = LONG_WAIT_CYC != 0;
    assign wait_last = CNT_W'(WAIT_CYC - 1);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = start ? S_SETUP_HI : S_IDLE;
            S_SETUP_HI: state_d = tc ? S_EN_HI : state_q;
            S_EN_HI:    state_d = tc ? S_HOLD_HI : state_q;
            S_HOLD_HI:  state_d = tc ? (NIB ? S_GAP : S_WAIT) : state_q;
            S_GAP:      state_d = tc ? S_SETUP_LO : state_q;
            S_SETUP_LO: state_d = tc ? S_EN_LO : state_q;
            S_EN_LO:    state_d = tc ? S_HOLD_LO : state_q;
            S_HOLD_LO:  state_d = tc ? S_WAIT : state_q;
            S_WAIT:     state_d = tc ? S_IDLE : state_q;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        last = wait_last;
        case (state_q)
            S_SETUP_HI, S_SETUP_LO: last = CNT_W'(SETUP_CYC - 1);
            S_EN_HI, S_EN_LO:       last = CNT_W'(EN_CYC - 1);
            S_HOLD_HI, S_HOLD_LO:   last = CNT_W'(HOLD_CYC - 1);
            S_GAP:                  last = CNT_W'(GAP_CYC - 1);
            default:                last = wait_last;
        endcase
    end

    // Every timed state exits on tc, so a state change is exactly a phase entry.
    assign clr = state_d != state_q || state_q == S_IDLE;

    lcd_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (clr),
        .last_i (last),
        .tc_o   (tc)
    );

    assign data_d = accept ? data_in : data_q;
    assign rs_d   = accept ? rs_in : rs_q;
    assign e_d    = state_d == S_EN_HI || state_d == S_EN_LO;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            e_q     <= e_d;
        end
    end

    assign hi = state_q == S_SETUP_HI || state_q == S_EN_HI || state_q == S_HOLD_HI || state_q == S_GAP;
    assign lo = state_q == S_SETUP_LO || state_q == S_EN_LO || state_q == S_HOLD_LO || state_q == S_WAIT;

    assign ready  = state_q == S_IDLE;
    assign done   = state_q == S_WAIT && tc;
    assign lcd_e  = e_q;
    assign lcd_rs = (hi || lo) && rs_q;
    assign lcd_rw = 1'b0;
    assign lcd_d  = hi ? (NIB ? {data_q[7:4], 4'h0} : data_q)
                  : lo ? (NIB ? {data_q[3:0], 4'h0} : data_q)
                  : 8'h00;

endmodule

// File: tb/tb_lcd_write_engine.sv
// tb_lcd_write_engine: three engine builds (4-bit defaults, 8-bit defaults,
// 4-bit all-ones timing) checked cycle by cycle against a phase-arithmetic pin model.
module tb_lcd_write_engine;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_v[3], rsin_v[3];
    logic [7:0] din_v[3];
    logic ready_v[3], done_v[3], e_v[3], rs_v[3], rw_v[3];
    logic [7:0] d_v[3];

    int nib[3] = '{1, 0, 1};
    int su[3]  = '{2, 2, 1};
    int en[3]  = '{12, 12, 1};
    int ho[3]  = '{1, 1, 1};
    int ga[3]  = '{47, 47, 1};
    int wt[3]  = '{2000, 2000, 1};
    int lw[3]  = '{82000, 82000, 1};
    int checks = 0;
    int passes = 0;

`ifdef LCD_LONG_WAIT_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    lcd_write_engine #(.NIBBLE_MODE(1)) dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .rs_in(rsin_v[0]), .data_in(din_v[0]),
        .ready(ready_v[0]), .done(done_v[0]), .lcd_e(e_v[0]), .lcd_rs(rs_v[0]), .lcd_rw(rw_v[0]), .lcd_d(d_v[0]));

    lcd_write_engine #(.NIBBLE_MODE(0)) dut8 (
        .clk(clk), .reset(reset), .start(start_v[1]), .rs_in(rsin_v[1]), .data_in(din_v[1]),
        .ready(ready_v[1]), .done(done_v[1]), .lcd_e(e_v[1]), .lcd_rs(rs_v[1]), .lcd_rw(rw_v[1]), .lcd_d(d_v[1]));

    lcd_write_engine #(.NIBBLE_MODE(1), .SETUP_CYC(1), .EN_CYC(1), .HOLD_CYC(1), .GAP_CYC(1),
                       .WAIT_CYC(1), .LONG_WAIT_CYC(1)) dutm (
        .clk(clk), .reset(reset), .start(start_v[2]), .rs_in(rsin_v[2]), .data_in(din_v[2]),
        .ready(ready_v[2]), .done(done_v[2]), .lcd_e(e_v[2]), .lcd_rs(rs_v[2]), .lcd_rw(rw_v[2]), .lcd_d(d_v[2]));

    function automatic int wait_len(int u, logic rs, logic [7:0] d);
        if (LONG_EN && !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return lw[u];
        return wt[u];
    endfunction

    function automatic int total(int u, logic rs, logic [7:0] d);
        if (nib[u] != 0) return 2 * (su[u] + en[u] + ho[u]) + ga[u] + wait_len(u, rs, d);
        return su[u] + en[u] + ho[u] + wait_len(u, rs, d);
    endfunction

    // {ready, done, e, rs, rw, d[7:0]} expected t cycles after the accept edge
    function automatic logic [12:0] expect_pins(int u, int t, logic rs, logic [7:0] d);
        int p1, p2, p3, p4, p5, p6, len;
        logic e;
        logic [7:0] xd;
        len = total(u, rs, d);
        if (t >= len) return {1'b1, 12'h000};
        p1 = su[u];
        p2 = p1 + en[u];
        p3 = p2 + ho[u];
        p4 = p3 + ga[u];
        p5 = p4 + su[u];
        p6 = p5 + en[u];
        e = (t >= p1 && t < p2) || (nib[u] != 0 && t >= p5 && t < p6);
        if (nib[u] == 0) xd = d;
        else xd = (t < p4) ? {d[7:4], 4'h0} : {d[3:0], 4'h0};
        return {1'b0, t == len - 1, e, rs, 1'b0, xd};
    endfunction

    function automatic logic [12:0] pins(int u);
        return {ready_v[u], done_v[u], e_v[u], rs_v[u], rw_v[u], d_v[u]};
    endfunction

    task automatic kick(input int u, input logic rs, input logic [7:0] d);
        @(negedge clk);
        start_v[u] = 1'b1;
        rsin_v[u]  = rs;
        din_v[u]   = d;
    endtask

    // Expects start already driven for the coming edge; leaves start = chain.
    task automatic xfer(input int u, input logic rs, input logic [7:0] d, input bit noise,
                        input bit chain, input logic nrs, input logic [7:0] nd, input string name);
        int len, bad, done_at;
        logic [12:0] o, x;
        len = total(u, rs, d);
        bad = 0;
        done_at = -1;
        for (int k = 1; k <= len + 1; k++) begin
            @(posedge clk);
            #1;
            o = pins(u);
            x = expect_pins(u, k - 1, rs, d);
            if (o !== x) begin
                if (bad == 0) $display("FAIL %s pins at cycle %0d: got %h want %h", name, k, o, x);
                bad++;
            end
            if (done_v[u] === 1'b1 && done_at < 0) done_at = k;
            @(negedge clk);
            if (k <= len) begin
                start_v[u] = noise & 1'($urandom);
                rsin_v[u]  = 1'($urandom);
                din_v[u]   = 8'($urandom);
            end else begin
                start_v[u] = chain;
                rsin_v[u]  = nrs;
                din_v[u]   = nd;
            end
        end
        checks++;
        if (bad == 0) passes++;
        checks++;
        if (done_at != len) $display("FAIL %s done_latency: got %0d want %0d", name, done_at, len);
        else passes++;
    endtask

    task automatic test_reset();
        for (int u = 0; u < 3; u++) begin
            start_v[u] = 1'b0;
            rsin_v[u]  = 1'b1;
            din_v[u]   = 8'hFF;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (pins(u) !== {1'b1, 12'h000}) $display("FAIL reset_state unit %0d: got %h want %h", u, pins(u), {1'b1, 12'h000});
            else passes++;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_4bit();
        kick(0, 1'b1, 8'hA5);
        xfer(0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, "4bit_a5");
        kick(0, 1'b0, 8'h01);
        xfer(0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00, "4bit_clear");
    endtask

    task automatic test_8bit();
        logic [7:0] d;
        logic r;
        kick(1, 1'b0, 8'h38);
        xfer(1, 1'b0, 8'h38, 1'b0, 1'b0, 1'b0, 8'h00, "8bit_38");
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom_range(4, 255));
            r = 1'($urandom);
            kick(1, r, d);
            xfer(1, r, d, 1'b1, 1'b0, 1'b0, 8'h00, "8bit_rand");
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic r;
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom_range(4, 255));
            r = 1'($urandom);
            kick(0, r, d);
            xfer(0, r, d, 1'b1, 1'b0, 1'b0, 8'h00, "4bit_rand");
        end
    endtask

    task automatic test_back_to_back(input int u, input int n, input string name);
        logic [7:0] d[$];
        logic r[$];
        for (int i = 0; i < n; i++) begin
            d.push_back(8'($urandom_range(4, 255)));
            r.push_back(1'($urandom));
        end
        kick(u, r[0], d[0]);
        for (int i = 0; i < n; i++)
            xfer(u, r[i], d[i], 1'b1, i < n - 1, (i < n - 1) ? r[i + 1] : 1'b0,
                 (i < n - 1) ? d[i + 1] : 8'h00, name);
    endtask

    task automatic test_reset_mid();
        int at;
        at = su[0] + en[0] + ho[0] + ga[0] + su[0] + 4;
        kick(0, 1'b1, 8'hC3);
        for (int k = 1; k <= at; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                @(negedge clk);
                start_v[0] = 1'b0;
            end
        end
        checks++;
        if (pins(0) !== expect_pins(0, at - 1, 1'b1, 8'hC3))
            $display("FAIL pre_reset_en_lo: got %h want %h", pins(0), expect_pins(0, at - 1, 1'b1, 8'hC3));
        else passes++;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (pins(0) !== {1'b1, 12'h000}) $display("FAIL async_reset_mid: got %h want %h", pins(0), {1'b1, 12'h000});
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        kick(0, 1'b0, 8'h5A);
        xfer(0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, "after_reset");
    endtask

    initial begin
        test_reset();
        test_4bit();
        test_8bit();
        test_random();
        test_back_to_back(0, 3, "b2b_4bit");
        test_reset_mid();
        test_back_to_back(2, 20, "min_timing");
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
